winograd_tile_scheduler: RTL and testbench



---
 rtl/winograd_pkg.sv | 22 ++
 rtl/winograd_tile_addr_gen.sv | 37 +++
 rtl/winograd_tile_scheduler.sv | 177 +++++++++++++++++
 tb/tb_winograd_tile_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and state encoding for the Winograd tile scheduler.
// Tiles are 6x6 inputs producing 4x4 outputs, stepped at stride 4.
package winograd_pkg;

    localparam int TILE_IN        = 6;
    localparam int TILE_OUT       = 4;
    localparam int STRIDE         = 4;
    localparam int STRIDE_LOG2    = $clog2(STRIDE);
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WRITE   = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/winograd_tile_addr_gen.sv
// Maps (tile index, element index) to an image/result position, its
// {row,col} address and whether it lies inside the active region.
module winograd_tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int MAX_DIM    = 32,
    parameter int ADDR_WIDTH = 2*$clog2(MAX_DIM)
)(
    input  logic [$clog2(MAX_DIM)-2:0] tile_r,
    input  logic [$clog2(MAX_DIM)-2:0] tile_c,
    input  logic [2:0]                 elem_i,
    input  logic [2:0]                 elem_j,
    input  logic [$clog2(MAX_DIM):0]   rows,
    input  logic [$clog2(MAX_DIM):0]   cols,
    input  logic                       wr_mode,
    output logic                       in_bounds,
    output logic [ADDR_WIDTH-1:0]      addr
);

    localparam int DIM_W = $clog2(MAX_DIM);

    logic [DIM_W+1:0] row, col, lim_r, lim_c;
    logic             rd_ok, wr_ok;

    assign row   = {1'b0, tile_r, {STRIDE_LOG2{1'b0}}} + (DIM_W+2)'(elem_i);
    assign col   = {1'b0, tile_c, {STRIDE_LOG2{1'b0}}} + (DIM_W+2)'(elem_j);
    assign lim_r = {1'b0, rows};
    assign lim_c = {1'b0, cols};

    // Output region is (R-2)x(C-2); compare pos+2 < dim to avoid a subtract.
    assign rd_ok = (row < lim_r) && (col < lim_c);
    assign wr_ok = ((row + (DIM_W+2)'(2)) < lim_r) && ((col + (DIM_W+2)'(2)) < lim_c);

    assign in_bounds = wr_mode ? wr_ok : rd_ok;
    assign addr      = ADDR_WIDTH'({row[DIM_W-1:0], col[DIM_W-1:0]});

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Walks the image in 6x6 tiles at stride 4, feeds tile_controller and
// writes the clipped 4x4 results back to the result RAM.
module winograd_tile_scheduler
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_DIM    = 32,
    parameter int ADDR_WIDTH = 2*$clog2(MAX_DIM)
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(MAX_DIM):0]   img_rows,
    input  logic [$clog2(MAX_DIM):0]   img_cols,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       img_rd_en,
    output logic [ADDR_WIDTH-1:0]      img_rd_addr,
    input  logic [DATA_WIDTH-1:0]      img_rd_data,
    output logic                       tc_start,
    output logic [0:TILE_IN-1][0:TILE_IN-1][DATA_WIDTH-1:0]   tc_tile,
    input  logic                       tc_done,
    input  logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_WIDTH-1:0] tc_result,
    output logic                       res_wr_en,
    output logic [ADDR_WIDTH-1:0]      res_wr_addr,
    output logic [DATA_WIDTH-1:0]      res_wr_data
);

    localparam int DIM_W  = $clog2(MAX_DIM);
    localparam int TIDX_W = DIM_W - 1;

    state_e            state;
    logic [DIM_W:0]    rows_q, cols_q;
    logic [TIDX_W-1:0] tile_r, tile_c, tile_r_nxt, tile_c_nxt;
    logic [2:0]        ei, ej;
    logic              cap_act, cap_inb, err_pend;
    logic [2:0]        cap_i, cap_j;
    logic              ag_inb, dims_ok, more_r, more_c, fetch_drain;
    logic [ADDR_WIDTH-1:0] ag_addr;

    winograd_tile_addr_gen #(
        .MAX_DIM    (MAX_DIM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .tile_r    (tile_r),
        .tile_c    (tile_c),
        .elem_i    (ei),
        .elem_j    (ej),
        .rows      (rows_q),
        .cols      (cols_q),
        .wr_mode   (state == ST_WRITE),
        .in_bounds (ag_inb),
        .addr      (ag_addr)
    );

    assign dims_ok = (img_rows >= (DIM_W+1)'(3)) && (img_rows <= (DIM_W+1)'(MAX_DIM)) &&
                     (img_cols >= (DIM_W+1)'(3)) && (img_cols <= (DIM_W+1)'(MAX_DIM));

    // A further tile exists while its origin lies inside the output region.
    assign tile_r_nxt = tile_r + 1'b1;
    assign tile_c_nxt = tile_c + 1'b1;
    assign more_r = ({1'b0, tile_r_nxt, {STRIDE_LOG2{1'b0}}} + (DIM_W+2)'(2)) < {1'b0, rows_q};
    assign more_c = ({1'b0, tile_c_nxt, {STRIDE_LOG2{1'b0}}} + (DIM_W+2)'(2)) < {1'b0, cols_q};

    // Final FETCH cycle only captures the last read; nothing is issued.
    assign fetch_drain = (ei == 3'(TILE_IN));

    assign img_rd_en   = (state == ST_FETCH) && !fetch_drain && ag_inb;
    assign img_rd_addr = img_rd_en ? ag_addr : '0;
    assign tc_start    = (state == ST_LAUNCH);
    assign res_wr_en   = (state == ST_WRITE) && ag_inb;
    assign res_wr_addr = res_wr_en ? ag_addr : '0;
    assign res_wr_data = res_wr_en ? tc_result[ei[1:0]][ej[1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            tile_r   <= '0;
            tile_c   <= '0;
            ei       <= '0;
            ej       <= '0;
            cap_act  <= 1'b0;
            cap_inb  <= 1'b0;
            cap_i    <= '0;
            cap_j    <= '0;
            err_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tc_tile  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_q  <= img_rows;
                        cols_q  <= img_cols;
                        tile_r  <= '0;
                        tile_c  <= '0;
                        ei      <= '0;
                        ej      <= '0;
                        cap_act <= 1'b0;
                        busy    <= 1'b1;
                        if (dims_ok) begin
                            state <= ST_FETCH;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    // Read data arrives one cycle after issue; padding captures as zero.
                    if (cap_act) tc_tile[cap_i][cap_j] <= cap_inb ? img_rd_data : '0;
                    cap_i   <= ei;
                    cap_j   <= ej;
                    cap_inb <= ag_inb;
                    if (fetch_drain) begin
                        cap_act <= 1'b0;
                        ei      <= '0;
                        ej      <= '0;
                        state   <= ST_LAUNCH;
                    end else begin
                        cap_act <= 1'b1;
                        if (ej == 3'(TILE_IN-1)) begin
                            ej <= '0;
                            ei <= ei + 3'd1;
                        end else begin
                            ej <= ej + 3'd1;
                        end
                    end
                end
                ST_LAUNCH:  state <= ST_WAIT_LO;
                ST_WAIT_LO: if (!tc_done) state <= ST_WAIT_HI;
                ST_WAIT_HI: if (tc_done)  state <= ST_WRITE;
                ST_WRITE: begin
                    if (ej == 3'(TILE_OUT-1)) begin
                        ej <= '0;
                        if (ei == 3'(TILE_OUT-1)) begin
                            ei    <= '0;
                            state <= ST_NEXT;
                        end else begin
                            ei <= ei + 3'd1;
                        end
                    end else begin
                        ej <= ej + 3'd1;
                    end
                end
                ST_NEXT: begin
                    if (more_c) begin
                        tile_c <= tile_c_nxt;
                        state  <= ST_FETCH;
                    end else if (more_r) begin
                        tile_c <= '0;
                        tile_r <= tile_r_nxt;
                        state  <= ST_FETCH;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    err      <= err_pend;
                    err_pend <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Scoreboard bench: stimulus pushes expected reads/tiles/writes, a negedge
// monitor pops and compares; tile_controller is modelled with centre tap = 1.
module tb_winograd_tile_scheduler;

    localparam int DW = 16;
    localparam int MD = 32;
    localparam int AW = 10;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [5:0] img_rows = '0, img_cols = '0;
    logic busy, done, err, img_rd_en, tc_start, res_wr_en;
    logic [AW-1:0] img_rd_addr, res_wr_addr;
    logic [DW-1:0] img_rd_data = '0, res_wr_data;
    logic [0:5][0:5][DW-1:0] tc_tile;
    logic [0:3][0:3][DW-1:0] tc_result = '0;
    logic tc_done;

    winograd_tile_scheduler #(.DATA_WIDTH(DW), .MAX_DIM(MD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_rows(img_rows), .img_cols(img_cols),
        .busy(busy), .done(done), .err(err), .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
        .img_rd_data(img_rd_data), .tc_start(tc_start), .tc_tile(tc_tile), .tc_done(tc_done),
        .tc_result(tc_result), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] res_mem [0:1023];
    int pass_cnt = 0, chk_cnt = 0;
    int exp_rd_q[$], exp_wa_q[$], exp_wd_q[$], tor_q[$], toc_q[$];
    int rd_cnt = 0, wr_cnt = 0, tcs_cnt = 0, done_cnt = 0, err_cnt = 0;
    int n_rd = 0, n_wr = 0, n_tiles = 0, cur_R = 0, cur_C = 0;

    task automatic chk(string name, longint got, longint exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Image RAM: one-cycle read latency.
    always @(posedge clk) if (img_rd_en) img_rd_data <= mem[img_rd_addr];

    // tile_controller model: done drops after start, rises after a random latency.
    int tcl_cnt;
    logic tcl_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_done  <= 1'b1;
            tcl_busy <= 1'b0;
            tcl_cnt  <= 0;
        end else if (tc_start) begin
            tc_done  <= 1'b0;
            tcl_busy <= 1'b1;
            tcl_cnt  <= $urandom_range(1, 6);
        end else if (tcl_busy) begin
            if (tcl_cnt == 0) begin
                tc_done  <= 1'b1;
                tcl_busy <= 1'b0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        tc_result[i][j] <= tc_tile[i+1][j+1];
            end else begin
                tcl_cnt <= tcl_cnt - 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin : mon
        int a, bad, r, c, tr0, tc0;
        logic [DW-1:0] ev;
        if (rst_n) begin
            if (img_rd_en) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) chk("rd_extra", img_rd_addr, -1);
                else begin
                    a = exp_rd_q.pop_front();
                    chk("rd_addr", img_rd_addr, a);
                end
            end
            if (tc_start) begin
                tcs_cnt++;
                if (tor_q.size() == 0) chk("tile_extra", 1, 0);
                else begin
                    tr0 = tor_q.pop_front();
                    tc0 = toc_q.pop_front();
                    bad = 0;
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 6; j++) begin
                            r = tr0 + i;
                            c = tc0 + j;
                            ev = (r < cur_R && c < cur_C) ? mem[r*32+c] : '0;
                            if (tc_tile[i][j] !== ev) bad++;
                        end
                    chk("tile_data_bad_elems", bad, 0);
                end
            end
            if (res_wr_en) begin
                wr_cnt++;
                res_mem[res_wr_addr] = res_wr_data;
                if (exp_wa_q.size() == 0) chk("wr_extra", res_wr_addr, -1);
                else begin
                    chk("wr_addr", res_wr_addr, exp_wa_q.pop_front());
                    chk("wr_data", res_wr_data, exp_wd_q.pop_front());
                end
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    // Reference model: build expected reads, tile origins and writes from the rules.
    task automatic prep(int R, int C, bit seq);
        cur_R = R;
        cur_C = C;
        for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
        for (int r = 0; r < R && r < 32; r++)
            for (int c = 0; c < C && c < 32; c++)
                mem[r*32+c] = seq ? DW'(r*C + c + 1) : DW'($urandom);
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        tor_q.delete(); toc_q.delete();
        n_rd = 0; n_wr = 0; n_tiles = 0;
        if (R >= 3 && R <= 32 && C >= 3 && C <= 32)
            for (int tr = 0; 4*tr < R-2; tr++)
                for (int tc = 0; 4*tc < C-2; tc++) begin
                    n_tiles++;
                    tor_q.push_back(4*tr);
                    toc_q.push_back(4*tc);
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 6; j++)
                            if (4*tr+i < R && 4*tc+j < C) begin
                                exp_rd_q.push_back((4*tr+i)*32 + 4*tc+j);
                                n_rd++;
                            end
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            if (4*tr+i < R-2 && 4*tc+j < C-2) begin
                                exp_wa_q.push_back((4*tr+i)*32 + 4*tc+j);
                                exp_wd_q.push_back(mem[(4*tr+i+1)*32 + 4*tc+j+1]);
                                n_wr++;
                            end
                end
        rd_cnt = 0; wr_cnt = 0; tcs_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic go(int R, int C);
        @(posedge clk); #1;
        img_rows = 6'(R);
        img_cols = 6'(C);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        img_rows = 6'($urandom);
        img_cols = 6'($urandom);
    endtask

    task automatic run(string name, int R, int C, bit seq, bit restart);
        bit seen;
        prep(R, C, seq);
        go(R, C);
        chk({name, "_busy_rise"}, busy, 1);
        if (restart) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 20000 && !seen; n++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_busy_fall"}, busy, 0);
        @(negedge clk); #1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_err_cnt"}, err_cnt, 0);
        chk({name, "_tiles"}, tcs_cnt, n_tiles);
        chk({name, "_reads"}, rd_cnt, n_rd);
        chk({name, "_writes"}, wr_cnt, n_wr);
        chk({name, "_rd_left"}, exp_rd_q.size(), 0);
        chk({name, "_wr_left"}, exp_wa_q.size(), 0);
    endtask

    task automatic run_err(string name, int R, int C);
        prep(R, C, 1'b0);
        go(R, C);
        chk({name, "_done_early"}, done, 0);
        @(posedge clk); #1;
        chk({name, "_done"}, done, 1);
        chk({name, "_err"}, err, 1);
        chk({name, "_busy"}, busy, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_reads"}, rd_cnt + tcs_cnt + wr_cnt, 0);
    endtask

    initial begin : stim
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {err, img_rd_en, tc_start, res_wr_en}, 0);
        chk("rst_addr", {img_rd_addr, res_wr_addr, res_wr_data}, 0);
        chk("rst_tile_zero", (tc_tile == '0), 1);
        rst_n = 1'b1;

        run("img6x6", 6, 6, 1'b1, 1'b0);
        chk("res_0_0", res_mem[0], 8);
        chk("res_3_3", res_mem[3*32+3], 29);
        run("img8x8", 8, 8, 1'b0, 1'b0);
        run("img7x5", 7, 5, 1'b0, 1'b0);
        run_err("err2x10", 2, 10);
        run_err("err33x5", 33, 5);
        run("restart", 10, 9, 1'b0, 1'b1);
        run("img3x32", 3, 32, 1'b0, 1'b0);
        run("img32x32", 32, 32, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            run("rand", $urandom_range(3, 32), $urandom_range(3, 32), 1'b0, 1'b0);

        // Abort mid-WRITE with reset.
        prep(8, 8, 1'b0);
        go(8, 8);
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(posedge clk); #1;
            if (res_wr_en && wr_cnt >= 4) seen = 1'b1;
        end
        chk("abort_write_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", res_wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_outs", {done, err, img_rd_en, tc_start}, 0);
        chk("abort_tile_zero", (tc_tile == '0), 1);
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        tor_q.delete(); toc_q.delete();
        rd_cnt = 0; wr_cnt = 0; tcs_cnt = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_writes", wr_cnt + rd_cnt + tcs_cnt, 0);
        run("after_abort", 6, 6, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
